// File: rtl/add8_rr_arbiter_pkg.sv
// Shared types for the two-requester adder arbiter.
package add8_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // requester id: 0 or 1
  typedef logic req_id_t;

endpackage

// File: rtl/add8_rr_arbiter_if.sv
// Request/response bundle between two clients and the shared-adder arbiter.
interface add8_rr_arbiter_if #(parameter int WIDTH = 8);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;

  // client side
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_sum, rsp_cout
  );

  // arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/add8_rr_arbiter_coreir_add.sv
// Plain combinational adder, the area-critical datapath being shared.
module coreir_add #(
  parameter int width = 16
) (
  input  logic [width-1:0] in0,
  input  logic [width-1:0] in1,
  output logic [width-1:0] out
);
  assign out = in0 + in1;
endmodule

// File: rtl/add8_rr_arbiter.sv
// Round-robin arbiter sharing one adder between two requesters, with a
// single registered result slot that can be drained and refilled in one cycle.
module add8_rr_arbiter
  import add8_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic CLK,
  input logic RESET,
  add8_rr_arbiter_if.slave bus
);

  state_t           state, state_nxt;
  req_id_t          owner, last_grant, gnt;
  logic             accept_ok, owner_rdy, xfer;
  logic [WIDTH-1:0] op_a, op_b, add_out;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // slot frees up this cycle if empty or if the owner is draining it now;
  // reset blocks any handshake in the same cycle
  always_comb begin
    owner_rdy = (owner == 1'b1) ? bus.rsp1_ready : bus.rsp0_ready;
    accept_ok = !RESET && ((state == IDLE) || owner_rdy);
  end

  // round-robin pick: a lone requester wins, on a tie the one not served last
  always_comb begin
    gnt = 1'b0;
    if (bus.req0_valid && bus.req1_valid) gnt = ~last_grant;
    else if (bus.req1_valid)              gnt = 1'b1;
    bus.req0_ready = accept_ok && bus.req0_valid && (gnt == 1'b0);
    bus.req1_ready = accept_ok && bus.req1_valid && (gnt == 1'b1);
    xfer           = bus.req0_ready || bus.req1_ready;
  end

  // operand mux steered by the grant feeds the shared adder
  always_comb begin
    op_a = gnt ? bus.req1_a : bus.req0_a;
    op_b = gnt ? bus.req1_b : bus.req0_b;
  end

  coreir_add #(.width(WIDTH)) u_add (
    .in0 (op_a),
    .in1 (op_b),
    .out (add_out)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state: a transfer always fills the slot, a bare drain empties it
  always_comb begin
    state_nxt = state;
    if (xfer)                           state_nxt = BUSY;
    else if (state == BUSY && owner_rdy) state_nxt = IDLE;
  end

  // response valid only toward the current owner
  always_comb begin
    bus.rsp0_valid = (state == BUSY) && (owner == 1'b0);
    bus.rsp1_valid = (state == BUSY) && (owner == 1'b1);
  end

  // result slot and round-robin history; held while the owner stalls
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sum_q      <= '0;
      cout_q     <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      sum_q      <= add_out;
      cout_q     <= (add_out < op_a);
      owner      <= gnt;
      last_grant <= gnt;
    end
  end

  assign bus.rsp_sum  = sum_q;
  assign bus.rsp_cout = cout_q;

endmodule

// File: tb/tb_add8_rr_arbiter.sv
// Directed bench for the two-requester shared-adder arbiter.
module tb_add8_rr_arbiter;

  logic CLK = 1'b0;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  add8_rr_arbiter_if #(.WIDTH(8)) bus ();

  add8_rr_arbiter #(.WIDTH(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       v0;
    logic [7:0] a0, b0;
    logic       v1;
    logic [7:0] a1, b1;
    logic       r0, r1;     // expected request readies this cycle
    logic       o0, o1;     // expected response valids next cycle
    logic       chk_sum;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic v1, input logic [7:0] a1, input logic [7:0] b1);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    // rsp readies high: every row drains the previous result and accepts anew
    tbl[0] = '{1, 8'h12, 8'h34, 1, 8'hAA, 8'hBB, 1, 0, 1, 0, 1, 8'h46, 0};
    tbl[1] = '{0, 8'h00, 8'h00, 1, 8'hF0, 8'h20, 0, 1, 0, 1, 1, 8'h10, 1};
    tbl[2] = '{1, 8'h01, 8'hFF, 1, 8'h11, 8'h22, 1, 0, 1, 0, 1, 8'h00, 1};
    tbl[3] = '{1, 8'h33, 8'h44, 1, 8'h7F, 8'h01, 0, 1, 0, 1, 1, 8'h80, 0};
    tbl[4] = '{1, 8'h80, 8'h80, 1, 8'h01, 8'h01, 1, 0, 1, 0, 1, 8'h00, 1};
    tbl[5] = '{1, 8'h05, 8'h06, 1, 8'h00, 8'h00, 0, 1, 0, 1, 1, 8'h00, 0};
    tbl[6] = '{0, 8'hFF, 8'hFF, 0, 8'hFF, 8'hFF, 0, 0, 0, 0, 0, 8'h00, 0};
    tbl[7] = '{0, 8'h00, 8'h00, 1, 8'hFF, 8'hFF, 0, 1, 0, 1, 1, 8'hFE, 1};
    tbl[8] = '{1, 8'h55, 8'hAA, 0, 8'h00, 8'h00, 1, 0, 1, 0, 1, 8'hFF, 0};

    // reset with both requesters asking
    RESET = 1'b1;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    drive(1, 8'h12, 8'h34, 1, 8'hAA, 8'hBB);
    step();
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    step();
    chk("rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("rst_rsp1_valid", bus.rsp1_valid, 0);
    chk("rst_sum", bus.rsp_sum, 0);
    chk("rst_cout", bus.rsp_cout, 0);
    RESET = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1);
      #1;
      chk($sformatf("row%0d_ready0", i), bus.req0_ready, tbl[i].r0);
      chk($sformatf("row%0d_ready1", i), bus.req1_ready, tbl[i].r1);
      step();
      chk($sformatf("row%0d_rsp0_valid", i), bus.rsp0_valid, tbl[i].o0);
      chk($sformatf("row%0d_rsp1_valid", i), bus.rsp1_valid, tbl[i].o1);
      if (tbl[i].chk_sum) begin
        chk($sformatf("row%0d_sum", i), bus.rsp_sum, tbl[i].sum);
        chk($sformatf("row%0d_cout", i), bus.rsp_cout, tbl[i].cout);
      end
    end

    // backpressure: req0 result (0xFF) pending, owner stalls for 3 cycles
    bus.rsp0_ready = 1'b0;
    drive(0, 8'h00, 8'h00, 1, 8'h03, 8'h04);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_ready1", c), bus.req1_ready, 0);
      chk($sformatf("bp%0d_rsp0_valid", c), bus.rsp0_valid, 1);
      chk($sformatf("bp%0d_sum", c), bus.rsp_sum, 8'hFF);
      step();
    end
    bus.rsp0_ready = 1'b1;
    #1;
    chk("bp_drain_ready1", bus.req1_ready, 1);
    step();
    chk("bp_rsp1_valid", bus.rsp1_valid, 1);
    chk("bp_rsp0_valid", bus.rsp0_valid, 0);
    chk("bp_sum", bus.rsp_sum, 8'h07);

    // reset while a req0 result is stalled
    bus.rsp0_ready = 1'b0;
    drive(1, 8'h10, 8'h20, 0, 8'h00, 8'h00);
    #1;
    chk("mid_ready0", bus.req0_ready, 1);
    step();
    chk("mid_rsp0_valid", bus.rsp0_valid, 1);
    chk("mid_sum", bus.rsp_sum, 8'h30);
    drive(1, 8'h01, 8'h02, 1, 8'h03, 8'h04);
    RESET = 1'b1;
    #1;
    chk("mid_rst_ready0", bus.req0_ready, 0);
    chk("mid_rst_ready1", bus.req1_ready, 0);
    step();
    chk("mid_rst_rsp0_valid", bus.rsp0_valid, 0);
    chk("mid_rst_sum", bus.rsp_sum, 0);
    RESET = 1'b0;
    #1;
    chk("post_rst_tie_ready0", bus.req0_ready, 1);
    chk("post_rst_tie_ready1", bus.req1_ready, 0);
    step();
    chk("post_rst_rsp0_valid", bus.rsp0_valid, 1);
    chk("post_rst_sum", bus.rsp_sum, 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
